// File: rtl/colorshield_if.sv
// Bundles the signals between the scanner, the pixel grid's column read port
// and the ColorShield DM163 pins.
//   col_bits     : 192-bit column from the grid, combinational in read_col_idx
//   read_col_idx : column currently addressed in the grid
//   sda/sck/lat  : DM163 serial data, serial clock (rising-edge sampled), latch
//   col_en       : one-hot column drive, active high
//   frame_done   : one-cycle pulse after column 7's hold completes
// master = scanner side, slave = grid/shield side.
interface colorshield_if;
  logic [191:0] col_bits;
  logic [2:0]   read_col_idx;
  logic         sda;
  logic         sck;
  logic         lat;
  logic [7:0]   col_en;
  logic         frame_done;

  modport master (
    input  col_bits,
    output read_col_idx, sda, sck, lat, col_en, frame_done
  );

  modport slave (
    output col_bits,
    input  read_col_idx, sda, sck, lat, col_en, frame_done
  );
endinterface

// File: rtl/colorshield_scanner.sv
// Continuously scans the 8x8 RGB grid onto the ColorShield. For each column:
// LOAD captures the column, SHIFT serializes it MSB-first to the DM163,
// LATCH strobes it into the driver outputs, DISPLAY drives the column enable
// for HOLD_CYCLES, then the next column is addressed.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   enable : 1 = scan continuously; 0 = stop at the next column boundary
//   cs     : colorshield_if.master (grid read port + DM163 pins)
// Every output to the pins comes straight from a register.
module colorshield_scanner #(
  parameter int CLK_DIV     = 4,     // clk cycles per SCK half-period, >= 1
  parameter int HOLD_CYCLES = 1000   // clk cycles a latched column is driven, >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  colorshield_if.master cs
);

  localparam int N_BITS = 192;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [7:0]        BIT_LAST  = 8'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    DISPLAY
  } state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]    div_q,   div_d;
  logic [7:0]          bit_q,   bit_d;
  logic [HOLD_W-1:0]   hold_q,  hold_d;
  logic [2:0]          col_q,   col_d;
  logic                sda_q,   sda_d;
  logic                sck_q,   sck_d;
  logic                lat_q,   lat_d;
  logic [7:0]          col_en_q, col_en_d;
  logic                frame_done_q, frame_done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    div_d        = div_q;
    bit_d        = bit_q;
    hold_d       = hold_q;
    col_d        = col_q;
    sck_d        = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end

      LOAD: begin
        // Snapshot the column; later grid writes cannot disturb it.
        shift_d = cs.col_bits;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        sck_d = sck_q;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = ~sck_q;
          // Advance data on the falling edge so sda is settled a full
          // half-period either side of the next rising edge.
          if (sck_q) begin
            shift_d = {shift_q[N_BITS-2:0], 1'b0};
            bit_d   = bit_q + 8'd1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = LATCH;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          hold_d  = '0;
          state_d = DISPLAY;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      DISPLAY: begin
        if (hold_q == HOLD_LAST) begin
          hold_d       = '0;
          col_d        = col_q + 3'd1;
          frame_done_d = (col_q == 3'd7);
          state_d      = enable ? LOAD : IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Pin values are decoded from the next state so the registered pins line
    // up exactly with the registered state.
    sda_d    = (state_d == SHIFT) ? shift_d[N_BITS-1] : 1'b0;
    lat_d    = (state_d == LATCH);
    col_en_d = (state_d == DISPLAY) ? (8'b1 << col_d) : 8'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      // NOTE: the 192-bit shift register is cleared as well so a reset
      // leaves no stale pixel data behind; it is flops, not a RAM.
      shift_q      <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      hold_q       <= '0;
      col_q        <= '0;
      sda_q        <= 1'b0;
      sck_q        <= 1'b0;
      lat_q        <= 1'b0;
      col_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      hold_q       <= hold_d;
      col_q        <= col_d;
      sda_q        <= sda_d;
      sck_q        <= sck_d;
      lat_q        <= lat_d;
      col_en_q     <= col_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cs.read_col_idx = col_q;
  assign cs.sda          = sda_q;
  assign cs.sck          = sck_q;
  assign cs.lat          = lat_q;
  assign cs.col_en       = col_en_q;
  assign cs.frame_done   = frame_done_q;

endmodule

// File: doc/colorshield_scanner.md
Name: colorshield_scanner

Overview:
- Read side of the 8x8 RGB pixel grid. Reads one 192-bit column at a time through the grid's column read port and serializes it MSB-first to the DM163 constant-current driver (SDA/SCK/LAT).
- After latching a column, drives that column's one-hot enable for a fixed hold time, then advances to the next column.
- Sits between the pixel grid and the ColorShield pins and scans continuously while enabled.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; must be >= 1.
- HOLD_CYCLES, 1000: clk cycles a latched column stays driven; must be >= 1.
- N_BITS, 192: bits per column (8 pixels x 24 bits); fixed.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = scan continuously, 0 = stop at the next column boundary.
- col_bits  in  192  column data from the grid; combinational function of read_col_idx.
- read_col_idx  out  3  column currently addressed in the grid.
- sda  out  1  serial data to DM163.
- sck  out  1  serial clock to DM163; DM163 samples sda on the rising edge.
- lat  out  1  DM163 latch strobe, active high.
- col_en  out  8  one-hot column drive, active high; bit k drives column k.
- frame_done  out  1  one-cycle pulse after column 7's hold completes.

Behaviour:
- Reset: rst=1 at a clock edge clears all state on that edge, regardless of current state or enable. After that edge:
  - read_col_idx=0, sda=0, sck=0, lat=0, col_en=0, frame_done=0.
  - FSM is in IDLE and the shift and hold counters are 0.
- IDLE:
  - All outputs low except read_col_idx, which holds its value.
  - enable=1 -> LOAD on the next cycle.
- LOAD (1 cycle):
  - Capture col_bits into a 192-bit shift register; read_col_idx is already stable.
  - col_en=0 (blanking). Next state is SHIFT.
- SHIFT:
  - sda = shift_reg[191] at all times; sck starts low.
  - sck toggles every CLK_DIV cycles.
  - On each sck falling transition the register shifts left by 1 and the bit counter increments.
  - Exactly 192 rising sck edges. sda is stable for at least CLK_DIV cycles before and after each rising edge.
  - State duration is 384*CLK_DIV cycles; SHIFT ends with sck=0.
  - col_en=0 throughout.
- LATCH:
  - lat=1 for exactly CLK_DIV cycles; sck=0, sda=0, col_en=0.
  - Next state is DISPLAY.
- DISPLAY:
  - col_en = 1 << read_col_idx for exactly HOLD_CYCLES cycles.
  - On the final cycle:
    - read_col_idx increments modulo 8 (7 wraps to 0).
    - If the column just held was 7, frame_done=1 on the following cycle only.
    - Next state is LOAD if enable=1, otherwise IDLE.
- Per-column period: 1 + 384*CLK_DIV + CLK_DIV + HOLD_CYCLES cycles.
- col_en is never nonzero while sck toggles or lat is high.
- enable deassertion: sampled only on the final DISPLAY cycle. Deasserting earlier lets the current column complete shift, latch and full hold. Re-enabling from IDLE resumes at the stored read_col_idx, not column 0.
- Grid writes mid-column: col_bits changing after LOAD has no effect on the column in flight.
- Bit order: col_bits[191] is shifted first, col_bits[0] last.
- Registered outputs: sda, sck, lat, col_en and frame_done all come from registers, with no combinational path from inputs.

Test Plan (CLK_DIV=2, HOLD_CYCLES=16 unless noted):
1. Reset: hold rst for 3 cycles during SHIFT, then release -> one edge after assertion all outputs are 0 and read_col_idx=0. With enable held at 0, outputs stay 0 for 50 cycles.
2. Serialization: col_bits = {8{24'hA5C30F}} for column 0, enable=1 -> 192 sck rises are counted. Bits sampled at each rise equal col_bits[191] down to [0]. SHIFT lasts 768 cycles. lat is high for exactly 2 cycles, starting the cycle after SHIFT ends.
3. Display timing: after that latch, col_en=8'h01 for exactly 16 cycles and is 0 during LOAD/SHIFT/LATCH. The next LOAD shows read_col_idx=1. Column period is 787 cycles.
4. Full frame and wrap: enable held high -> read_col_idx steps 0..7 then 0. col_en equals 8'h80 during column 7's hold. frame_done pulses exactly once per 8 columns, 1 cycle wide, and is 0 at all other times.
5. Enable drop: deassert enable at the 100th SHIFT cycle of column 3 -> column 3 still finishes 192 bits, latch and 16-cycle hold with col_en=8'h08. FSM then goes to IDLE with read_col_idx=4. Re-enabling restarts at column 4.
6. Mid-column grid update: change col_bits in the 10th SHIFT cycle of column 2 -> the serialized stream equals the value captured in LOAD. The new value appears only on column 2's next visit.
